// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic-light controller and its receive-side monitor.
package traffic_light_pkg;

   // Lamp phase as decoded from the red/yellow/green outputs.
   typedef enum logic [1:0] {
      PH_RED     = 2'd0,
      PH_GREEN   = 2'd1,
      PH_YELLOW  = 2'd2,
      PH_INVALID = 2'd3
   } phase_t;

   // Fault codes; only the first one since the last clear is kept.
   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_DARK    = 3'd1;
   localparam logic [2:0] FC_MULTI   = 3'd2;
   localparam logic [2:0] FC_ILLEGAL = 3'd3;
   localparam logic [2:0] FC_SHORT   = 3'd4;
   localparam logic [2:0] FC_LONG    = 3'd5;

   // Monitor FSM: SYNC waits for a valid lamp sample, TRACK checks the sequence.
   typedef enum logic {
      MON_SYNC  = 1'b0,
      MON_TRACK = 1'b1
   } mon_state_t;

   // Normal (non-emergency) successor of a phase in the RED->GREEN->YELLOW cycle.
   function automatic phase_t legal_successor(input phase_t p);
      case (p)
         PH_RED:    return PH_GREEN;
         PH_GREEN:  return PH_YELLOW;
         PH_YELLOW: return PH_RED;
         default:   return PH_INVALID;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_monitor_lamp_decode.sv
// Combinational lamp decoder: exactly one lamp lit gives a phase, anything else is INVALID.
module lamp_decode
   import traffic_light_pkg::*;
(
   input  logic   red,
   input  logic   yellow,
   input  logic   green,
   output phase_t phase,
   output logic   dark,
   output logic   multi
);

   // One-hot lamps map to a phase; all-dark and multi-lit are flagged separately.
   always_comb begin
      phase = PH_INVALID;
      dark  = 1'b0;
      multi = 1'b0;
      case ({red, yellow, green})
         3'b100:  phase = PH_RED;
         3'b010:  phase = PH_YELLOW;
         3'b001:  phase = PH_GREEN;
         3'b000:  dark  = 1'b1;
         default: multi = 1'b1;
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light controller: decodes the lamp phase,
// measures dwell per phase and latches the first protocol violation.
// Every output is registered one edge after the sample it describes.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int RED_TICKS    = 6,
   parameter int GREEN_TICKS  = 6,
   parameter int YELLOW_TICKS = 3,
   parameter int DWELL_W      = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               red,
   input  logic               yellow,
   input  logic               green,
   input  logic               emergency,
   input  logic               clear_fault,
   output logic [1:0]         phase,
   output logic [DWELL_W-1:0] dwell,
   output logic               cycle_done,
   output logic [15:0]        cycle_count,
   output logic               fault,
   output logic [2:0]         fault_code,
   output mon_state_t         monitor_state
);

   localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
   localparam logic [DWELL_W-1:0] RED_T     = DWELL_W'(RED_TICKS);
   localparam logic [DWELL_W-1:0] GREEN_T   = DWELL_W'(GREEN_TICKS);
   localparam logic [DWELL_W-1:0] YELLOW_T  = DWELL_W'(YELLOW_TICKS);

   // Required dwell of a phase; INVALID never gets checked.
   function automatic logic [DWELL_W-1:0] ticks_of(input phase_t p);
      case (p)
         PH_RED:    return RED_T;
         PH_GREEN:  return GREEN_T;
         PH_YELLOW: return YELLOW_T;
         default:   return DWELL_MAX;
      endcase
   endfunction

   phase_t             dec_phase;
   logic               dec_dark;
   logic               dec_multi;

   mon_state_t         state_q, state_d;
   phase_t             phase_q, phase_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] held_dwell;
   logic               first_q, first_d;   // still in the first phase after (re)sync
   logic               emg_prev;
   logic               done_d;
   logic               new_fault;
   logic [2:0]         new_code;
   logic               same_phase;
   logic               legal_step;
   logic               emg_green;

   lamp_decode u_decode (
      .red    (red),
      .yellow (yellow),
      .green  (green),
      .phase  (dec_phase),
      .dark   (dec_dark),
      .multi  (dec_multi)
   );

   assign phase         = phase_q;
   assign dwell         = dwell_q;
   assign monitor_state = state_q;

   assign same_phase = (dec_phase == phase_q);
   assign held_dwell = (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + 1'b1;
   // GREEN under an active emergency does not accumulate dwell.
   assign emg_green  = (dec_phase == PH_GREEN) && emergency;

   // Next-state, dwell and fault evaluation for the current lamp sample.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      dwell_d    = dwell_q;
      first_d    = first_q;
      done_d     = 1'b0;
      new_fault  = 1'b0;
      new_code   = FC_NONE;
      legal_step = 1'b0;

      if (dec_dark || dec_multi) begin
         new_fault = 1'b1;
         new_code  = dec_dark ? FC_DARK : FC_MULTI;
         state_d   = MON_SYNC;
         phase_d   = PH_INVALID;
         dwell_d   = '0;
         first_d   = 1'b0;
      end else if (state_q == MON_SYNC) begin
         // First valid sample: adopt the phase without judging how we got here.
         state_d = MON_TRACK;
         phase_d = dec_phase;
         dwell_d = emg_green ? '0 : DWELL_W'(1);
         first_d = 1'b1;
      end else begin
         phase_d = dec_phase;
         if (!same_phase) begin
            legal_step = (dec_phase == legal_successor(phase_q)) ||
                         ((dec_phase == PH_GREEN) && emg_prev);
            dwell_d    = emg_green ? '0 : DWELL_W'(1);
            first_d    = 1'b0;
            done_d     = (phase_q == PH_YELLOW) && (dec_phase == PH_RED) && !emg_prev;
         end else begin
            dwell_d = emg_green ? '0 : held_dwell;
         end

         if ((!same_phase && !legal_step) || (emg_prev && dec_phase != PH_GREEN)) begin
            new_fault = 1'b1;
            new_code  = FC_ILLEGAL;
         end else if (!same_phase && !first_q && !emergency && !emg_prev &&
                      (dwell_q < ticks_of(phase_q))) begin
            new_fault = 1'b1;
            new_code  = FC_SHORT;
         end else if (same_phase && !emergency && (held_dwell > ticks_of(dec_phase))) begin
            new_fault = 1'b1;
            new_code  = FC_LONG;
         end
      end
   end

   // State registers, cycle counter and sticky fault latch (a new fault beats a clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= MON_SYNC;
         phase_q     <= PH_INVALID;
         dwell_q     <= '0;
         first_q     <= 1'b0;
         emg_prev    <= 1'b0;
         cycle_done  <= 1'b0;
         cycle_count <= '0;
         fault       <= 1'b0;
         fault_code  <= FC_NONE;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         dwell_q    <= dwell_d;
         first_q    <= first_d;
         emg_prev   <= emergency;
         cycle_done <= done_d;
         if (done_d && (cycle_count != 16'hFFFF))
            cycle_count <= cycle_count + 16'd1;
         if (clear_fault) begin
            fault      <= 1'b0;
            fault_code <= FC_NONE;
         end
         if (new_fault && (!fault || clear_fault)) begin
            fault      <= 1'b1;
            fault_code <= new_code;
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: a reference model predicts every cycle's outputs,
// a monitor compares them one edge later, and directed checks pin the key scenarios.
module tb_traffic_light_monitor;
  import traffic_light_pkg::*;

  localparam int RT = 6;
  localparam int GT = 6;
  localparam int YT = 3;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic reset, red, yellow, green, emergency, clear_fault;
  logic [1:0]  phase;
  logic [7:0]  dwell;
  logic        cycle_done;
  logic [15:0] cycle_count;
  logic        fault;
  logic [2:0]  fault_code;
  mon_state_t  monitor_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_synced, m_first, m_emg_prev, m_fault, m_done;
  int m_phase, m_dwell, m_code, m_count;
  int ticks[3] = '{RT, GT, YT};

  traffic_light_monitor #(
    .RED_TICKS(RT), .GREEN_TICKS(GT), .YELLOW_TICKS(YT), .DWELL_W(8)
  ) dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .emergency(emergency), .clear_fault(clear_fault), .phase(phase), .dwell(dwell),
    .cycle_done(cycle_done), .cycle_count(cycle_count), .fault(fault),
    .fault_code(fault_code), .monitor_state(monitor_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phases cycle 0->1->2->0, GREEN reachable from anywhere after emergency.
  function automatic logic [W-1:0] model_step(bit r, bit y, bit g, bit e, bit c, bit rs);
    int n, p, fc;
    bit chg, legal;
    fc = 0;
    m_done = 0;
    if (rs) begin
      m_synced = 0; m_first = 0; m_emg_prev = 0; m_fault = 0;
      m_phase = 3; m_dwell = 0; m_code = 0; m_count = 0;
    end else begin
      n = int'(r) + int'(y) + int'(g);
      if (n != 1) begin
        fc = (n == 0) ? 1 : 2;
        m_synced = 0; m_first = 0; m_phase = 3; m_dwell = 0;
      end else begin
        p = r ? 0 : (g ? 1 : 2);
        if (!m_synced) begin
          m_synced = 1; m_first = 1; m_phase = p;
          m_dwell = (p == 1 && e) ? 0 : 1;
        end else begin
          chg = (p != m_phase);
          legal = !chg || (p == (m_phase + 1) % 3) || (p == 1 && m_emg_prev);
          if (!legal || (m_emg_prev && p != 1)) fc = 3;
          else if (chg && !m_first && !e && !m_emg_prev && m_dwell < ticks[m_phase]) fc = 4;
          else if (!chg && !e && m_dwell + 1 > ticks[p]) fc = 5;
          if (chg) begin
            m_done = (m_phase == 2 && p == 0 && !m_emg_prev);
            m_first = 0;
            m_dwell = (p == 1 && e) ? 0 : 1;
          end else begin
            m_dwell = (p == 1 && e) ? 0 : ((m_dwell < 255) ? m_dwell + 1 : 255);
          end
          m_phase = p;
        end
      end
      if (m_done && m_count < 65535) m_count++;
      if (c) begin m_fault = 0; m_code = 0; end
      if (fc != 0 && !m_fault) begin m_fault = 1; m_code = fc; end
      m_emg_prev = e;
    end
    return {m_synced, 2'(m_phase), 8'(m_dwell), m_done, 16'(m_count), m_fault, 3'(m_code)};
  endfunction

  // driver tasks
  task automatic drive(input bit r, input bit y, input bit g, input bit e, input bit c, input bit rs);
    @(negedge clk);
    red = r; yellow = y; green = g; emergency = e; clear_fault = c; reset = rs;
    exp_q.push_back(model_step(r, y, g, e, c, rs));
  endtask

  task automatic drive_ph(input int p, input bit e, input bit c);
    drive(p == 0, p == 2, p == 1, e, c, 1'b0);
  endtask

  task automatic nominal(input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = i % 15;
      drive_ph((k < 6) ? 0 : ((k < 12) ? 1 : 2), 1'b0, 1'b0);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // scoreboard monitor: one expected word per clock edge
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",       32'(monitor_state == MON_TRACK), 32'(e[31]));
      check("phase",       32'(phase),       32'(e[30:29]));
      check("dwell",       32'(dwell),       32'(e[28:21]));
      check("cycle_done",  32'(cycle_done),  32'(e[20]));
      check("cycle_count", 32'(cycle_count), 32'(e[19:4]));
      check("fault",       32'(fault),       32'(e[3]));
      check("fault_code",  32'(fault_code),  32'(e[2:0]));
    end
  end

  initial begin
    int cp;
    reset = 1'b1; red = 0; yellow = 0; green = 0; emergency = 0; clear_fault = 0;

    // reset state
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 1, 1, 1);
    settle();
    check("rst_phase", 32'(phase), 32'd3);
    check("rst_dwell", 32'(dwell), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // nominal controller, 46 samples
    nominal(46);
    settle();
    check("nom_done46", 32'(cycle_done), 32'd1);
    check("nom_count",  32'(cycle_count), 32'd3);
    check("nom_fault",  32'(fault), 32'd0);

    // MULTI then resync on RED
    drive(1, 0, 1, 0, 0, 0);
    settle();
    check("multi_fault", 32'(fault), 32'd1);
    check("multi_code",  32'(fault_code), 32'd2);
    check("multi_phase", 32'(phase), 32'd3);
    drive_ph(0, 0, 0);
    settle();
    check("resync_phase", 32'(phase), 32'd0);
    check("resync_code",  32'(fault_code), 32'd2);

    // YELLOW held 4 samples -> LONG
    drive_ph(0, 0, 1);
    repeat (4) drive_ph(0, 0, 0);
    repeat (6) drive_ph(1, 0, 0);
    repeat (4) drive_ph(2, 0, 0);
    settle();
    check("long_code", 32'(fault_code), 32'd5);

    // GREEN 4 samples -> SHORT, then clear
    drive_ph(0, 0, 1);
    repeat (5) drive_ph(0, 0, 0);
    repeat (4) drive_ph(1, 0, 0);
    drive_ph(2, 0, 0);
    settle();
    check("short_code", 32'(fault_code), 32'd4);
    drive_ph(2, 0, 1);
    settle();
    check("clear_fault", 32'(fault), 32'd0);
    check("clear_code",  32'(fault_code), 32'd0);

    // emergency during RED dwell 3, held 10 cycles
    drive_ph(2, 0, 0);
    repeat (2) drive_ph(0, 0, 0);
    drive_ph(0, 1, 0);
    repeat (9) drive_ph(1, 1, 0);
    repeat (GT) drive_ph(1, 0, 0);
    repeat (YT) drive_ph(2, 0, 0);
    drive_ph(0, 0, 0);
    settle();
    check("emg_fault", 32'(fault), 32'd0);
    check("emg_done",  32'(cycle_done), 32'd1);

    // RED->YELLOW illegal, then DARK wins over clear
    drive_ph(0, 0, 0);
    drive_ph(2, 0, 0);
    settle();
    check("illegal_code", 32'(fault_code), 32'd3);
    drive(0, 0, 0, 0, 1, 0);
    settle();
    check("dark_fault", 32'(fault), 32'd1);
    check("dark_code",  32'(fault_code), 32'd1);

    // dwell saturation
    repeat (260) drive_ph(0, 0, 0);
    settle();
    check("dwell_sat", 32'(dwell), 32'd255);

    // randomized controller-like traffic with faults, emergencies and resets
    drive(0, 0, 0, 0, 0, 1);
    cp = 0;
    for (int seg = 0; seg < 60; seg++) begin
      int sel, len;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) begin
        logic [2:0] lam;
        lam = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'(3 + $urandom_range(0, 4));
        if (lam == 3'b100) lam = 3'b111;
        drive(lam[2], lam[1], lam[0], 1'b0, $urandom_range(0, 3) == 0, 1'b0);
      end else if (sel == 1) begin
        drive(1, 0, 0, 0, 0, 1);
        cp = 0;
      end else if (sel == 2) begin
        drive_ph(cp, 1, 0);
        len = int'($urandom_range(0, 3));
        repeat (len) drive_ph(1, 1, 0);
        len = GT - 1 + int'($urandom_range(0, 2));
        repeat (len) drive_ph(1, 0, 0);
        cp = 1;
      end else begin
        cp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2)) : (cp + 1) % 3;
        len = ticks[cp] - 1 + int'($urandom_range(0, 3));
        if (len < 1) len = 1;
        repeat (len) drive_ph(cp, $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0);
      end
    end

    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
